// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller: forward-select
// encoding, default register-address width and the forward priority helper.
package hazard_fwd_ctrl_pkg;

    localparam int DEF_ASIZE = 4;

    typedef enum logic [1:0] {
        FWD_RF     = 2'd0,  // register file read
        FWD_EXMEM  = 2'd1,  // EX/MEM aluout
        FWD_MEMWB  = 2'd2,  // MEM/WB write data
        FWD_WBHOLD = 2'd3   // registered copy of last cycle's write data
    } fwd_sel_e;

    // Youngest producer wins; a load still in EX cannot forward (it stalls),
    // so its hit is skipped and older entries are considered instead.
    function automatic fwd_sel_e fwd_pick(input logic h0, input logic h0_ld,
                                          input logic h1, input logic h2);
        if (h0 && !h0_ld) return FWD_EXMEM;
        if (h1)           return FWD_MEMWB;
        if (h2)           return FWD_WBHOLD;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    // Count events, sticking at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_cnt <= '0;
        else if (clr)                   r_cnt <= '0;
        else if (inc && (r_cnt != '1))  r_cnt <= r_cnt + W'(1);
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage core. Tracks destinations in
// EX/MEM/WB, raises load-use stalls and branch/jump flushes, and registers the
// EX operand forward selects one cycle after an instruction leaves ID.
import hazard_fwd_ctrl_pkg::*;

module hazard_fwd_ctrl #(
    parameter int ASIZE       = DEF_ASIZE,
    parameter int LINK_REG    = 15,
    parameter bit ZERO_REG_EN = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [ASIZE-1:0] id_raddr1,
    input  logic [ASIZE-1:0] id_raddr2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [ASIZE-1:0] id_waddr,
    input  logic             id_wen,
    input  logic             id_memread,
    input  logic             id_jal,
    input  logic             id_jump,
    input  logic             ex_branch_taken,
    input  logic             ext_stall,
    input  logic             clr_cnt,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [2:0]       stage_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [ASIZE-1:0] LINK = ASIZE'(LINK_REG);

    // Scoreboard: index 0 = EX, 1 = MEM, 2 = WB
    logic [2:0]            r_vld, r_wen, r_ld;
    logic [2:0][ASIZE-1:0] r_waddr;
    fwd_sel_e              r_fwd_a, r_fwd_b;

    logic [2:0]       w_hit_a, w_hit_b;
    logic             w_zero_a, w_zero_b, w_lu, w_bubble;
    logic             w_stall_inc, w_flush_inc, w_wen;
    logic [ASIZE-1:0] w_dst;

    assign w_dst    = id_jal ? LINK : id_waddr;
    assign w_wen    = id_wen | id_jal;
    assign w_zero_a = ZERO_REG_EN && (id_raddr1 == '0);
    assign w_zero_b = ZERO_REG_EN && (id_raddr2 == '0);

    // Match each used ID source against every live writing entry
    always_comb begin
        w_hit_a = '0;
        w_hit_b = '0;
        for (int i = 0; i < 3; i++) begin
            w_hit_a[i] = id_use1 & r_vld[i] & r_wen[i] & (r_waddr[i] == id_raddr1) & ~w_zero_a;
            w_hit_b[i] = id_use2 & r_vld[i] & r_wen[i] & (r_waddr[i] == id_raddr2) & ~w_zero_b;
        end
    end

    assign w_lu = id_valid & r_ld[0] & (w_hit_a[0] | w_hit_b[0]);

    // Pipeline control, highest priority first: freeze, taken branch, load-use, jump
    always_comb begin
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        w_bubble    = 1'b0;
        if (ext_stall) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
        end else if (ex_branch_taken) begin
            flush_if_id = 1'b1;
            w_bubble    = 1'b1;
        end else if (w_lu) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            w_bubble    = 1'b1;
        end else if (id_jump) begin
            flush_if_id = 1'b1;
        end
    end

    assign bubble_id_ex = w_bubble;

    // Advance the scoreboard and capture forward selects; frozen under ext_stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= '0;
            r_wen   <= '0;
            r_ld    <= '0;
            r_waddr <= '0;
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (!ext_stall) begin
            r_vld   <= {r_vld[1:0], id_valid & ~w_bubble};
            r_wen   <= {r_wen[1:0], w_wen & ~w_bubble};
            r_ld    <= {r_ld[1:0],  id_memread & ~w_bubble};
            r_waddr <= {r_waddr[1:0], w_dst};
            r_fwd_a <= w_bubble ? FWD_RF : fwd_pick(w_hit_a[0], r_ld[0], w_hit_a[1], w_hit_a[2]);
            r_fwd_b <= w_bubble ? FWD_RF : fwd_pick(w_hit_b[0], r_ld[0], w_hit_b[1], w_hit_b[2]);
        end
    end

    assign fwd_a_sel   = r_fwd_a;
    assign fwd_b_sel   = r_fwd_b;
    assign stage_valid = {r_vld[2], r_vld[1], r_vld[0]};

    // Only events that actually take effect are counted (a freeze masks both)
    assign w_stall_inc = ~ext_stall & ~ex_branch_taken & w_lu;
    assign w_flush_inc = ~ext_stall & ex_branch_taken;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_stall_inc),
        .clr (clr_cnt),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_flush_inc),
        .clr (clr_cnt),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl. Two instances share stimulus: variant 0 uses the
// default parameters, variant 1 has ZERO_REG_EN=0 and CNT_W=2. A history-based
// model predicts every output each cycle; literal checks pin key scenarios.
module tb_hazard_fwd_ctrl;

    logic       clk, rst;
    logic       id_valid, id_use1, id_use2, id_wen, id_memread, id_jal, id_jump;
    logic [3:0] id_raddr1, id_raddr2, id_waddr;
    logic       ex_branch_taken, ext_stall, clr_cnt;

    logic        sp0, si0, fl0, bb0, sp1, si1, fl1, bb1;
    logic [1:0]  fa0, fb0, fa1, fb1;
    logic [2:0]  sv0, sv1;
    logic [15:0] sc0, fc0;
    logic [1:0]  sc1, fc1;

    int checks = 0;
    int errors = 0;

    hazard_fwd_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
        .id_use1(id_use1), .id_use2(id_use2), .id_waddr(id_waddr), .id_wen(id_wen),
        .id_memread(id_memread), .id_jal(id_jal), .id_jump(id_jump),
        .ex_branch_taken(ex_branch_taken), .ext_stall(ext_stall), .clr_cnt(clr_cnt),
        .stall_pc(sp0), .stall_if_id(si0), .flush_if_id(fl0), .bubble_id_ex(bb0),
        .fwd_a_sel(fa0), .fwd_b_sel(fb0), .stage_valid(sv0), .stall_cnt(sc0), .flush_cnt(fc0)
    );

    hazard_fwd_ctrl #(.ZERO_REG_EN(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
        .id_use1(id_use1), .id_use2(id_use2), .id_waddr(id_waddr), .id_wen(id_wen),
        .id_memread(id_memread), .id_jal(id_jal), .id_jump(id_jump),
        .ex_branch_taken(ex_branch_taken), .ext_stall(ext_stall), .clr_cnt(clr_cnt),
        .stall_pc(sp1), .stall_if_id(si1), .flush_if_id(fl1), .bubble_id_ex(bb1),
        .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stage_valid(sv1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- model: last three issued instructions, youngest first
    typedef struct {bit v; int dst; bit wen; bit ld;} slot_t;
    slot_t hist[2][3];
    int m_fa[2], m_fb[2], m_sc[2], m_fc[2];

    function automatic bit zen(int k);
        return (k == 0);
    endfunction

    function automatic int cmax(int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    function automatic bit writes(int k, int d, int s, bit u);
        return u && hist[k][d].v && hist[k][d].wen && hist[k][d].dst == s && !(zen(k) && s == 0);
    endfunction

    function automatic bit m_lu(int k);
        return id_valid && hist[k][0].ld &&
               (writes(k, 0, int'(id_raddr1), id_use1) || writes(k, 0, int'(id_raddr2), id_use2));
    endfunction

    // Distance to the nearest earlier producer, skipping a load that is only one ahead
    function automatic int youngest(int k, int s, bit u);
        for (int d = 0; d < 3; d++)
            if (writes(k, d, s, u) && !(d == 0 && hist[k][0].ld)) return d + 1;
        return 0;
    endfunction

    function automatic int m_haz(int k);
        if (ext_stall)       return 4'b1100;
        if (ex_branch_taken) return 4'b0011;
        if (m_lu(k))         return 4'b1101;
        if (id_jump)         return 4'b0010;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int d = 0; d < 3; d++) hist[k][d] <= '{v: 0, dst: 0, wen: 0, ld: 0};
                m_fa[k] <= 0; m_fb[k] <= 0; m_sc[k] <= 0; m_fc[k] <= 0;
            end else begin
                if (!ext_stall) begin
                    hist[k][2] <= hist[k][1];
                    hist[k][1] <= hist[k][0];
                    hist[k][0] <= '{v: id_valid && !(ex_branch_taken || m_lu(k)),
                                    dst: id_jal ? 15 : int'(id_waddr),
                                    wen: id_wen || id_jal, ld: id_memread};
                    m_fa[k] <= (ex_branch_taken || m_lu(k)) ? 0 : youngest(k, int'(id_raddr1), id_use1);
                    m_fb[k] <= (ex_branch_taken || m_lu(k)) ? 0 : youngest(k, int'(id_raddr2), id_use2);
                end
                if (clr_cnt) begin
                    m_sc[k] <= 0;
                    m_fc[k] <= 0;
                end else if (!ext_stall) begin
                    if (!ex_branch_taken && m_lu(k) && m_sc[k] < cmax(k)) m_sc[k] <= m_sc[k] + 1;
                    if (ex_branch_taken && m_fc[k] < cmax(k))            m_fc[k] <= m_fc[k] + 1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        chk("haz0", int'({sp0, si0, fl0, bb0}), m_haz(0));
        chk("haz1", int'({sp1, si1, fl1, bb1}), m_haz(1));
        chk("fa0", int'(fa0), m_fa[0]);
        chk("fb0", int'(fb0), m_fb[0]);
        chk("fa1", int'(fa1), m_fa[1]);
        chk("fb1", int'(fb1), m_fb[1]);
        chk("sv0", int'(sv0), int'({hist[0][2].v, hist[0][1].v, hist[0][0].v}));
        chk("sv1", int'(sv1), int'({hist[1][2].v, hist[1][1].v, hist[1][0].v}));
        chk("sc0", int'(sc0), m_sc[0]);
        chk("fc0", int'(fc0), m_fc[0]);
        chk("sc1", int'(sc1), m_sc[1]);
        chk("fc1", int'(fc1), m_fc[1]);
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input int ra, input int rb, input bit ua, input bit ub,
                          input int wa, input bit we, input bit ld);
        id_valid = v; id_raddr1 = 4'(ra); id_raddr2 = 4'(rb);
        id_use1 = ua; id_use2 = ub; id_waddr = 4'(wa); id_wen = we; id_memread = ld;
        id_jal = 1'b0; id_jump = 1'b0;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    task automatic haz0(input string name, input int exp);
        chk(name, int'({sp0, si0, fl0, bb0}), exp);
    endtask

    initial begin
        rst = 1'b1; ex_branch_taken = 0; ext_stall = 0; clr_cnt = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_sv", int'(sv0), 0);
        chk("rst_fa", int'(fa0), 0);
        chk("rst_sc", int'(sc0), 0);

        // back-to-back ALU dependency -> EX/MEM forward
        set_id(1, 2, 3, 1, 1, 1, 1, 0); tick();
        set_id(1, 1, 3, 1, 1, 2, 1, 0); #1 haz0("add_sub_nostall", 0);
        tick();
        chk("fwd1_a", int'(fa0), 1); chk("fwd1_b", int'(fb0), 0); chk("fwd1_sv", int'(sv0), 3'b011);
        idle(3);
        // one independent instruction between -> MEM/WB
        set_id(1, 2, 3, 1, 1, 1, 1, 0); tick();
        set_id(1, 6, 7, 1, 1, 5, 1, 0); tick();
        set_id(1, 1, 3, 1, 1, 2, 1, 0); tick();
        chk("fwd2_a", int'(fa0), 2);
        idle(3);
        // two between -> WB hold
        set_id(1, 2, 3, 1, 1, 1, 1, 0); tick();
        set_id(1, 6, 7, 1, 1, 5, 1, 0); tick(); tick();
        set_id(1, 1, 3, 1, 1, 2, 1, 0); tick();
        chk("fwd3_a", int'(fa0), 3);
        idle(3);
        // three between -> register file
        set_id(1, 2, 3, 1, 1, 1, 1, 0); tick();
        set_id(1, 6, 7, 1, 1, 5, 1, 0); tick(); tick(); tick();
        set_id(1, 1, 3, 1, 1, 2, 1, 0); tick();
        chk("fwd0_a", int'(fa0), 0);
        idle(3);

        // load-use: one stall cycle then MEM/WB forward on both operands
        set_id(1, 0, 0, 0, 0, 3, 1, 1); tick();
        set_id(1, 3, 3, 1, 1, 4, 1, 0); #1 haz0("lu_stall", 4'b1101);
        tick();
        haz0("lu_release", 0); chk("lu_cnt", int'(sc0), 1); chk("lu_sv", int'(sv0), 3'b010);
        tick();
        chk("lu_fa", int'(fa0), 2); chk("lu_fb", int'(fb0), 2);
        idle(3);

        // taken branch overrides load-use
        set_id(1, 0, 0, 0, 0, 3, 1, 1); tick();
        set_id(1, 3, 3, 1, 1, 4, 1, 0); ex_branch_taken = 1; #1 haz0("br_flush", 4'b0011);
        tick(); ex_branch_taken = 0;
        chk("br_fcnt", int'(fc0), 1); chk("br_scnt", int'(sc0), 1);
        idle(3);
        set_id(1, 0, 0, 0, 0, 0, 0, 0); id_jump = 1; #1 haz0("jump", 4'b0010);
        idle(3);

        // jal writes the link register
        set_id(1, 0, 0, 0, 0, 0, 0, 0); id_jal = 1; tick();
        set_id(1, 15, 6, 1, 1, 5, 1, 0); tick();
        chk("jal_fa", int'(fa0), 1); chk("jal_fb", int'(fb0), 0);
        idle(3);
        // register 0 writer/reader
        set_id(1, 2, 2, 0, 0, 0, 1, 0); tick();
        set_id(1, 0, 0, 1, 1, 6, 1, 0); tick();
        chk("r0_zen1", int'(fa0), 0); chk("r0_zen0_a", int'(fa1), 1); chk("r0_zen0_b", int'(fb1), 1);
        idle(3);

        // external freeze during a load-use
        set_id(1, 0, 0, 0, 0, 2, 1, 0); tick();
        set_id(1, 2, 0, 1, 0, 3, 1, 1); tick();
        chk("frz_pre_fa", int'(fa0), 1); chk("frz_pre_sv", int'(sv0), 3'b011);
        set_id(1, 3, 3, 1, 1, 4, 1, 0); ext_stall = 1; #1 haz0("frz_haz", 4'b1100);
        repeat (4) tick();
        chk("frz_sv", int'(sv0), 3'b011); chk("frz_fa", int'(fa0), 1); chk("frz_sc", int'(sc0), 1);
        ext_stall = 0; #1 haz0("frz_lu", 4'b1101);
        tick();
        chk("frz_sc_after", int'(sc0), 2);
        tick();
        chk("frz_fa_after", int'(fa0), 2); chk("frz_fb_after", int'(fb0), 2);
        idle(3);

        // five more stalls: 16-bit counter reaches 7, 2-bit one saturates
        repeat (5) begin
            set_id(1, 0, 0, 0, 0, 3, 1, 1); tick();
            set_id(1, 3, 3, 1, 1, 4, 1, 0); tick(); tick();
        end
        chk("sat_sc0", int'(sc0), 7); chk("sat_sc1", int'(sc1), 3);
        idle(3);

        // asynchronous reset while a load-use stall is active
        set_id(1, 0, 0, 0, 0, 3, 1, 1); tick();
        set_id(1, 3, 3, 1, 1, 4, 1, 0); #1 haz0("pre_rst_lu", 4'b1101);
        #1 rst = 1'b1;
        #1;
        haz0("rst_drop_lu", 0); chk("rst_mid_sv", int'(sv0), 0);
        chk("rst_mid_sc", int'(sc0), 0); chk("rst_mid_fc", int'(fc0), 0);
        chk("rst_mid_fa", int'(fa0), 0); chk("rst_mid_fb", int'(fb0), 0);
        @(posedge clk); #1 rst = 1'b0;
        idle(2);

        // clear coincident with an increment
        set_id(1, 0, 0, 0, 0, 3, 1, 1); tick();
        set_id(1, 3, 3, 1, 1, 4, 1, 0); tick(); tick();
        chk("clr_pre", int'(sc0), 1);
        set_id(1, 0, 0, 0, 0, 3, 1, 1); tick();
        set_id(1, 3, 3, 1, 1, 4, 1, 0); clr_cnt = 1; #1 haz0("clr_lu", 4'b1101);
        tick(); clr_cnt = 0;
        chk("clr_sc0", int'(sc0), 0); chk("clr_sc1", int'(sc1), 0);
        tick();
        chk("clr_hold", int'(sc0), 0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Parametrised hazard/forwarding controller for the 16-bit 5-stage core (IF, ID, EX, MEM, WB).
- Replaces the core's hazard-free pipeline control with a scoreboard of in-flight destinations in EX, MEM and WB.
- Generates load-use stalls, branch/jump flushes and registered operand-forwarding selects aligned to EX.
- Provides saturating stall/flush performance counters.

Parameters:
ASIZE, 4, register address width (2**ASIZE registers)
LINK_REG, 15, destination register forced for jal
ZERO_REG_EN, 1, 1 = register 0 never matches (never forwarded, never stalls)
CNT_W, 16, performance counter width

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous reset, active-high
id_valid  in  1  instruction in ID is real (not bubble)
id_raddr1  in  ASIZE  ID source register A
id_raddr2  in  ASIZE  ID source register B
id_use1  in  1  instruction reads source A
id_use2  in  1  instruction reads source B
id_waddr  in  ASIZE  ID destination register
id_wen  in  1  ID instruction writes regfile
id_memread  in  1  ID instruction is a load
id_jal  in  1  ID instruction is jal (destination = LINK_REG)
id_jump  in  1  jump/jr resolved in ID
ex_branch_taken  in  1  branch resolved taken in EX
ext_stall  in  1  external freeze (e.g. memory wait)
clr_cnt  in  1  synchronous counter clear
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID register
flush_if_id  out  1  squash IF/ID contents
bubble_id_ex  out  1  load NOP into ID/EX
fwd_a_sel  out  2  EX operand A source: 0 regfile, 1 EX/MEM aluout, 2 MEM/WB wdata, 3 WB-hold (datapath's registered copy of previous-cycle wdata)
fwd_b_sel  out  2  as fwd_a_sel, for operand B
stage_valid  out  3  [0]=EX, [1]=MEM, [2]=WB entry valid
stall_cnt  out  CNT_W  load-use stall cycles
flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
Scoreboard
- Three entries e0 (EX), e1 (MEM), e2 (WB), each holding {valid, waddr, wen, memread}.
- Effective destination = id_jal ? LINK_REG : id_waddr; wen_eff = id_wen | id_jal.
Matching
- Source S hits entry e when: use bit set, e.valid & e.wen, e.waddr==S, and not (ZERO_REG_EN & S==0).
Load-use hazard (lu)
- Either used source hits e0 while e0.memread=1, and id_valid=1.
Combinational outputs, in priority order
1. ext_stall=1: stall_pc=stall_if_id=1, flush_if_id=0, bubble_id_ex=0.
2. ex_branch_taken=1: flush_if_id=1, bubble_id_ex=1, no stall. lu is ignored; the ID instruction dies.
3. lu=1: stall_pc=stall_if_id=1, bubble_id_ex=1.
4. id_jump=1: flush_if_id=1 only.
- Otherwise all four outputs are 0.
Sequential update (posedge clk; nothing changes while ext_stall=1)
- e2<=e1, e1<=e0.
- e0 <= bubble_id_ex ? invalid : ID fields with valid=id_valid.
- fwd_x_sel <= bubble_id_ex ? 0 : youngest hit, per source:
  - e0 hit (non-load) -> 1
  - else e1 hit -> 2
  - else e2 hit -> 3
  - else 0
- A load hit in e1 or e2 forwards normally (2/3).
Forwarding timing
- One cycle after capture, the consumer is in EX and the producer is in MEM (1), WB (2), or already written (3).
Counters (saturate at all-ones)
- stall_cnt += 1 each cycle lu wins priority (case 3).
- flush_cnt += 1 each cycle case 2 is active.
- clr_cnt clears both; clear wins over increment.
Reset
- rst asserted clears all entries, fwd selects and counters immediately, independent of clk.
- stage_valid=0 and combinational outputs then follow the inputs.
- Reset mid-stall drops the stall next evaluation (e0 invalid).
Latency
- Hazard outputs are combinational, same cycle.
- Forward selects are 1-cycle registered.

Decomposition:
- Shared package (define.v): FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2, FWD_WBHOLD=3; ASIZE.
- One sub-module, sat_counter (CNT_W, inc, clr), instantiated twice.
- Scoreboard and priority logic stay inline.

Test Plan:
1. rst pulse mid-run (asynchronous, between edges) -> stage_valid=000, fwd_a_sel=fwd_b_sel=0, stall_cnt=flush_cnt=0 before next edge.
2. ADD r1 then SUB r2,r1,r3 back-to-back -> no stall; next cycle fwd_a_sel=1, fwd_b_sel=0. Insert 1 and 2 independent instructions between them -> fwd_a_sel=2 and 3. Insert 3 -> fwd_a_sel=0.
3. LW r3 then ADD r4,r3,r3 -> exactly one cycle of stall_pc=stall_if_id=bubble_id_ex=1 and stall_cnt=1; then fwd_a_sel=fwd_b_sel=2.
4. LW r3 in EX and a dependent instruction in ID with ex_branch_taken=1 -> flush_if_id=1, bubble_id_ex=1, stall_pc=0; flush_cnt=1, stall_cnt unchanged.
5. jal then ADD r5,r15 -> fwd_a_sel=1. ADD r0 writer then r0 reader with ZERO_REG_EN=1 -> fwd 0. Same with ZERO_REG_EN=0 -> fwd 1.
6. ext_stall held 4 cycles during the load-use case -> scoreboard and fwd selects frozen, stall_cnt unchanged. CNT_W=2 with 5 load-use stalls -> stall_cnt=3. clr_cnt coincident with an increment -> 0.
